// File: rtl/hybrid_pwm_sd_mc.sv
// hybrid_pwm_sd_mc: multi-channel hybrid PWM / first-order sigma-delta audio DAC
module hybrid_pwm_sd_mc #(
    parameter int CHANNELS  = 2,
    parameter int DW        = 16,
    parameter int PWM_BITS  = 5,
    parameter int SIGNED_IN = 1
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic [CHANNELS*DW-1:0] din,
    input  logic                   din_valid,
    input  logic                   mute,
    output logic [CHANNELS-1:0]    dout,
    output logic                   frame
);
    // scaled sample never reaches 2**(DW+PWM_BITS), so this width is exact
    localparam int SW = DW + PWM_BITS;
    localparam logic [PWM_BITS-1:0] MID_THR = PWM_BITS'(1) << (PWM_BITS - 1);
    localparam logic [DW-1:0]       MID_DW  = DW'(1) << (DW - 1);
    localparam logic [DW-1:0]       IN_XOR  = (SIGNED_IN != 0) ? MID_DW : '0;
    localparam logic [SW-1:0]       GAIN    = SW'((1 << PWM_BITS) - 2);
    localparam logic [SW-1:0]       OFFSET  = SW'(1) << DW;

    logic [PWM_BITS-1:0] cnt;
    logic [DW-1:0]       hold     [CHANNELS];
    logic [DW-1:0]       acc      [CHANNELS];
    logic [PWM_BITS-1:0] thr      [CHANNELS];
    logic [SW-1:0]       s        [CHANNELS];
    logic [DW:0]         acc_sum  [CHANNELS];
    logic [PWM_BITS-1:0] thr_next [CHANNELS];
    logic                boundary;

    assign boundary = (cnt == '1);

    // Scale each held sample to an integer count plus a fraction fed to the accumulator
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            s[k]        = SW'(hold[k]) * GAIN + OFFSET;
            acc_sum[k]  = {1'b0, acc[k]} + {1'b0, s[k][DW-1:0]};
            thr_next[k] = s[k][DW +: PWM_BITS] + PWM_BITS'(acc_sum[k][DW]);
        end
    end

    // Shared frame counter; frame pulses in the first cycle running the new thresholds
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt   <= '0;
            frame <= 1'b0;
        end else begin
            cnt   <= cnt + PWM_BITS'(1);
            frame <= boundary;
        end
    end

    // Sample hold, stored offset-binary so the scaler never sees signed data
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int k = 0; k < CHANNELS; k++) hold[k] <= MID_DW;
        end else if (din_valid) begin
            for (int k = 0; k < CHANNELS; k++) hold[k] <= din[k*DW +: DW] ^ IN_XOR;
        end
    end

    // Per-frame duty update; mute parks at midscale and freezes the accumulator
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                thr[k] <= MID_THR;
                acc[k] <= MID_DW;
            end
        end else if (boundary) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (mute) begin
                    thr[k] <= MID_THR;
                end else begin
                    thr[k] <= thr_next[k];
                    acc[k] <= acc_sum[k][DW-1:0];
                end
            end
        end
    end

    // PWM comparator, one registered pin per channel
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            dout <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) dout[k] <= (cnt < thr[k]);
        end
    end
endmodule

// File: tb/tb_hybrid_pwm_sd_mc.sv
// tb_hybrid_pwm_sd_mc: scoreboard bench counting high clocks per PWM frame on unsigned and signed instances
module tb_hybrid_pwm_sd_mc;
    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        mute = 1'b0;
    logic [1:0]  dout_u, dout_s;
    logic        frame_u, frame_s;

    int n_checks = 0;
    int n_fail = 0;
    int exp_q[$];
    int hi[4];
    int period = 0;
    bit seen = 1'b0;
    string ch_name[4] = '{"u_ch0", "u_ch1", "s_ch0", "s_ch1"};

    always #5 clk = ~clk;

    hybrid_pwm_sd_mc #(.CHANNELS(2), .DW(16), .PWM_BITS(5), .SIGNED_IN(0)) dut_u (
        .clk(clk), .n_reset(n_reset), .din(din), .din_valid(din_valid),
        .mute(mute), .dout(dout_u), .frame(frame_u)
    );

    hybrid_pwm_sd_mc #(.CHANNELS(2), .DW(16), .PWM_BITS(5), .SIGNED_IN(1)) dut_s (
        .clk(clk), .n_reset(n_reset), .din(din), .din_valid(din_valid),
        .mute(mute), .dout(dout_s), .frame(frame_s)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // monitor: accumulate high clocks, close the window on each frame pulse and compare
    always @(negedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < 4; i++) hi[i] = 0;
            period = 0;
            seen = 1'b0;
        end else begin
            hi[0] += int'(dout_u[0]);
            hi[1] += int'(dout_u[1]);
            hi[2] += int'(dout_s[0]);
            hi[3] += int'(dout_s[1]);
            period++;
            if (frame_u) begin
                if (seen) check("frame_period", period, 32);
                check("frame_s_sync", int'(frame_s), 1);
                if (exp_q.size() >= 4) begin
                    for (int i = 0; i < 4; i++) check(ch_name[i], hi[i], exp_q.pop_front());
                end else begin
                    check("sb_queue_depth", exp_q.size(), 4);
                end
                for (int i = 0; i < 4; i++) hi[i] = 0;
                period = 0;
                seen = 1'b1;
            end
        end
    end

    // advance to the next frame pulse and queue the duty expected for the window ending there
    task automatic step(input int a, input int b, input int c, input int d);
        int n = 0;
        @(posedge clk); #1;
        din_valid = 1'b0;
        while (!frame_u && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!frame_u) check("frame_timeout", int'(frame_u), 1);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic strobe(input logic [15:0] c0, input logic [15:0] c1);
        din = {c1, c0};
        din_valid = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        // reset state: midscale on every channel of both instances
        repeat (3) step(16, 16, 16, 16);
        strobe(16'h0000, 16'h8000);
        step(16, 16, 16, 16);
        step(1, 16, 16, 1);
        step(1, 16, 16, 1);
        // half-LSB fraction dithers 9/8 and 24/23
        strobe(16'h4000, 16'hC000);
        step(1, 16, 16, 1);
        step(9, 24, 24, 9);
        step(8, 23, 23, 8);
        step(9, 24, 24, 9);
        mute = 1'b1;
        step(8, 23, 23, 8);
        step(16, 16, 16, 16);
        step(16, 16, 16, 16);
        mute = 1'b0;
        // three muted frames: a running accumulator would resume on 8, the held one on 9
        step(16, 16, 16, 16);
        step(9, 24, 24, 9);
        step(8, 23, 23, 8);
        // strobe in the boundary cycle must not reach that boundary's threshold
        repeat (31) @(posedge clk);
        #1 strobe(16'h8000, 16'h0000);
        step(9, 24, 24, 9);
        step(8, 23, 23, 8);
        step(16, 1, 1, 16);
        // full-scale input stays below a solid frame
        strobe(16'hFFFF, 16'h7FFF);
        step(16, 1, 1, 16);
        step(31, 16, 16, 31);
        step(31, 16, 16, 31);
        // asynchronous reset mid-frame while outputs are high
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_dout_u", int'(dout_u), 3);
        n_reset = 1'b0;
        #1;
        check("rst_dout_u", int'(dout_u), 0);
        check("rst_dout_s", int'(dout_s), 0);
        check("rst_frame", int'(frame_u), 0);
        #20 n_reset = 1'b1;
        repeat (3) step(16, 16, 16, 16);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
